mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the CPU load/store path.
- Sits beside the data BRAM and decodes a 16-word window at the top of the address space.
- Serves LEDs, switches, button edge events and a prescaled down-counting timer with interrupt flag.
- Read data is registered, giving the same one-cycle latency as the BRAM, so top-level writeback selects between the BRAM output and this block's read data using hit_q.

Parameters:
- BASE_ADDR, 16'hFF00, window base; bits [3:0] must be zero; window = BASE_ADDR..BASE_ADDR+15.
- LED_W, 10, LED register width.
- SW_W, 10, switch input width.
- BTN_W, 4, button input width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- addr  in  16  load/store address (same value driven to the BRAM address).
- wdata  in  16  store data (Rsrc bus).
- we  in  1  store strobe (same as the BRAM write enable).
- sw  in  SW_W  raw switch inputs, asynchronous.
- btn  in  BTN_W  raw buttons, asynchronous, active-high.
- rdata  out  16  registered read data.
- hit_q  out  1  registered: previous-cycle addr was inside the window.
- led  out  LED_W  LED register.
- irq  out  1  timer done AND interrupt enable.

Behaviour:
- Decode: sel = (addr[15:4] == BASE_ADDR[15:4]); off = addr[3:0]; wr = we & sel.
- Register map (offset, access):
  - 0 LED: R/W, low LED_W bits; upper read bits are 0.
  - 1 SW: RO, 2-flop synchronized sw, zero-extended.
  - 2 TLOAD: R/W; a write also copies into TCOUNT.
  - 3 TCOUNT: RO.
  - 4 TCTRL: bit0 EN, bit1 AUTO, bit2 IE are R/W; bit3 DONE reads 1 when set, write-1-to-clear; other bits read 0.
  - 5 PRESC: R/W, 16-bit.
  - 6 BTNEVT: sticky rising-edge flags, low BTN_W bits, W1C.
  - 7-15: read 0, writes ignored, hit_q still asserted.
- Reads:
  - Every cycle, rdata <= sel ? reg[off] : 16'h0000 and hit_q <= sel.
  - Latency is exactly 1 cycle.
  - Reads have no side effects.
  - Writes take effect at the clock edge where wr=1; a read of the same register on the next cycle returns the new value.
- Synchronizers: sw and btn each pass through 2 flops. Button edge = sync & ~sync_prev (3rd flop). An edge sets BTNEVT[i].
- Prescaler pcnt (16-bit):
  - EN=0: pcnt <= PRESC and no tick.
  - EN=1: if pcnt==0 then tick=1 and pcnt <= PRESC; else pcnt <= pcnt-1.
  - Tick period = PRESC+1 cycles. PRESC=0 gives a tick every cycle.
- Timer on tick:
  - TCOUNT>1: decrement.
  - TCOUNT==1: TCOUNT <= 0 and DONE <= 1.
  - TCOUNT==0: if AUTO then TCOUNT <= TLOAD, else hold. No new DONE.
- irq = DONE & IE, combinational from registers.
- Simultaneous events:
  - Hardware set beats W1C clear in the same cycle (DONE and BTNEVT).
  - A TLOAD write beats a same-cycle tick decrement: TCOUNT takes the written value.
  - A PRESC write does not disturb the running pcnt; it takes effect at the next reload.
- Wrap-around: none. Counters never underflow. TCOUNT holds at 0 unless AUTO.
- Reset (rst==0 at posedge), including mid-count:
  - Cleared to 0: rdata, hit_q, led, TLOAD, TCOUNT, TCTRL (all bits), PRESC, pcnt, BTNEVT, all sync flops. irq=0.
  - Reset overrides a same-cycle write.
- Addresses outside the window: no register change, hit_q=0, rdata=0.

Test Plan:
- Reset, then write 16'h03A5 to FF00 -> led=10'h3A5; a read of FF00 one cycle later gives rdata=16'h03A5, hit_q=1. Read 16'h0100 -> hit_q=0, rdata=0.
- Set sw=10'h155 -> FF01 reads 16'h0155 no earlier than 2 cycles after the change. Raise btn[2] and hold -> FF06 reads 16'h0004 and stays set. Write 16'h0004 to FF06 -> reads 0. A new edge in the same cycle as the clear leaves the bit at 1.
- Write FF05=2, FF02=3, FF04=16'h0005 (EN, IE) -> ticks every 3 cycles; TCOUNT steps 3,2,1,0; DONE and irq rise 9 cycles after EN; TCOUNT then holds 0.
- Same setup with AUTO (FF04=16'h0007) -> after reaching 0, the next tick reloads 3. Write 16'h0008 to FF04 -> DONE clears and irq drops, unless DONE is re-set that cycle.
- Write FF02=16'h0010 in the same cycle as a tick -> TCOUNT=16'h0010. Assert rst=0 for one cycle mid-count -> every register reads 0, led=0, irq=0.

Source files
------------

// File: rtl/mmio_responder.sv
// Purpose: MMIO responder for a 16-word window (LEDs, switches, button events, prescaled timer).
// Latency: read data and hit_q are registered, 1 cycle after the address, like the data BRAM.
// Backpressure: none; a load or store is accepted every cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   addr, wdata, we   CPU load/store address, store data, store strobe
//   sw, btn           raw asynchronous switch and button inputs
//   rdata, hit_q      registered read data and previous-cycle window hit
//   led, irq          LED register, timer interrupt (DONE & IE)
module mmio_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          LED_W     = 10,
  parameter int          SW_W      = 10,
  parameter int          BTN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [15:0]      rdata,
  output logic             hit_q,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_SW     = 4'd1;
  localparam logic [3:0] OFF_TLOAD  = 4'd2;
  localparam logic [3:0] OFF_TCOUNT = 4'd3;
  localparam logic [3:0] OFF_TCTRL  = 4'd4;
  localparam logic [3:0] OFF_PRESC  = 4'd5;
  localparam logic [3:0] OFF_BTNEVT = 4'd6;

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
  logic [BTN_W-1:0] r_btn_s1, r_btn_s2, r_btn_s3;
  logic [BTN_W-1:0] r_btnevt;
  logic [15:0]      r_tload, r_tcount, r_presc, r_pcnt;
  logic             r_en, r_auto, r_ie, r_done;
  logic [15:0]      r_rdata;
  logic             r_hit;

  logic             w_sel;
  logic [3:0]       w_off;
  logic             w_wr;
  logic             w_tick;
  logic             w_done_set;
  logic [BTN_W-1:0] w_btn_rise;
  logic [BTN_W-1:0] w_btn_clr;
  logic [15:0]      w_rd;

  assign w_sel      = (addr[15:4] == BASE_ADDR[15:4]);
  assign w_off      = addr[3:0];
  assign w_wr       = we & w_sel;
  assign w_tick     = r_en & (r_pcnt == 16'd0);
  // DONE is raised by the tick that expires the count, even if a TLOAD
  // write in the same cycle overrides the count itself.
  assign w_done_set = w_tick & (r_tcount == 16'd1);
  assign w_btn_rise = r_btn_s2 & ~r_btn_s3;
  assign w_btn_clr  = (w_wr && w_off == OFF_BTNEVT) ? wdata[BTN_W-1:0] : '0;

  always_comb begin
    w_rd = 16'h0000;
    if (w_sel) begin
      case (w_off)
        OFF_LED:    w_rd[LED_W-1:0] = r_led;
        OFF_SW:     w_rd[SW_W-1:0]  = r_sw_s2;
        OFF_TLOAD:  w_rd            = r_tload;
        OFF_TCOUNT: w_rd            = r_tcount;
        OFF_TCTRL:  w_rd[3:0]       = {r_done, r_ie, r_auto, r_en};
        OFF_PRESC:  w_rd            = r_presc;
        OFF_BTNEVT: w_rd[BTN_W-1:0] = r_btnevt;
        default:    w_rd            = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led    <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_s3 <= '0;
      r_btnevt <= '0;
      r_tload  <= '0;
      r_tcount <= '0;
      r_presc  <= '0;
      r_pcnt   <= '0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_ie     <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      r_rdata  <= w_rd;
      r_hit    <= w_sel;

      if (w_wr && w_off == OFF_LED)   r_led   <= wdata[LED_W-1:0];
      if (w_wr && w_off == OFF_TLOAD) r_tload <= wdata;
      if (w_wr && w_off == OFF_PRESC) r_presc <= wdata;
      if (w_wr && w_off == OFF_TCTRL) begin
        r_en   <= wdata[0];
        r_auto <= wdata[1];
        r_ie   <= wdata[2];
      end

      // Hardware set wins over a same-cycle write-1-to-clear.
      if (w_done_set)
        r_done <= 1'b1;
      else if (w_wr && w_off == OFF_TCTRL && wdata[3])
        r_done <= 1'b0;
      r_btnevt <= (r_btnevt & ~w_btn_clr) | w_btn_rise;

      // Reload uses the current PRESC, so a PRESC write only lands at the next reload.
      if (!r_en || r_pcnt == 16'd0)
        r_pcnt <= r_presc;
      else
        r_pcnt <= r_pcnt - 16'd1;

      if (w_wr && w_off == OFF_TLOAD)
        r_tcount <= wdata;
      else if (w_tick) begin
        if (r_tcount > 16'd1)
          r_tcount <= r_tcount - 16'd1;
        else if (r_tcount == 16'd1)
          r_tcount <= 16'd0;
        else if (r_auto)
          r_tcount <= r_tload;
      end
    end
  end

  assign rdata = r_rdata;
  assign hit_q = r_hit;
  assign led   = r_led;
  assign irq   = r_done & r_ie;

endmodule

// File: tb/tb_mmio_responder.sv
// Purpose: scoreboard bench for mmio_responder against a behavioural register-map model.
// Latency: expectations are pushed per cycle and popped 1 ns after the following clock edge.
// Backpressure: none; one expectation per driven cycle.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        we = 1'b0;
  logic [9:0]  sw = 10'h000;
  logic [3:0]  btn = 4'h0;
  logic [15:0] rdata;
  logic        hit_q;
  logic [9:0]  led;
  logic        irq;

  always #5 clk = ~clk;

  mmio_responder #(
    .BASE_ADDR(16'hFF00), .LED_W(10), .SW_W(10), .BTN_W(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .sw(sw), .btn(btn), .rdata(rdata), .hit_q(hit_q), .led(led), .irq(irq)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        hit;
    logic [9:0]  led;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [9:0]  m_led = '0;
  logic [15:0] m_tload = '0, m_tc = '0, m_presc = '0, m_pc = '0;
  logic        m_en = 0, m_auto = 0, m_ie = 0, m_done = 0;
  logic [3:0]  m_bev = '0;
  logic [9:0]  m_sh [0:1];   // sw samples: [0] last edge, [1] two edges ago
  logic [3:0]  m_bh [0:2];   // btn samples: [0] last edge ... [2] three edges ago

  initial begin
    m_sh[0] = '0; m_sh[1] = '0;
    m_bh[0] = '0; m_bh[1] = '0; m_bh[2] = '0;
  end

  function automatic logic [15:0] m_read(input logic [3:0] off);
    case (off)
      4'd0: return {6'b0, m_led};
      4'd1: return {6'b0, m_sh[1]};
      4'd2: return m_tload;
      4'd3: return m_tc;
      4'd4: return {12'b0, m_done, m_ie, m_auto, m_en};
      4'd5: return m_presc;
      4'd6: return {12'b0, m_bev};
      default: return 16'h0000;
    endcase
  endfunction

  // Drive one cycle at the current negedge, record what the DUT must show
  // after the coming posedge, advance the model, then move to the next negedge.
  task automatic step(input logic r, input logic [15:0] a, input logic w, input logic [15:0] d);
    exp_t e;
    logic sel, wr, tick;
    logic [3:0] off;
    logic [15:0] n_pc, n_tc;
    rst = r; addr = a; we = w; wdata = d;
    sel = (a[15:4] == 12'hFF0);
    off = a[3:0];
    wr  = w && sel;
    if (!r) begin
      m_led = '0; m_tload = '0; m_tc = '0; m_presc = '0; m_pc = '0;
      m_en = 0; m_auto = 0; m_ie = 0; m_done = 0; m_bev = '0;
      m_sh[0] = '0; m_sh[1] = '0;
      m_bh[0] = '0; m_bh[1] = '0; m_bh[2] = '0;
      e.rdata = 16'h0; e.hit = 1'b0;
    end else begin
      e.rdata = sel ? m_read(off) : 16'h0;
      e.hit   = sel;
      tick = m_en && (m_pc == 0);
      // prescaler: counts PRESC..0 while enabled, a tick on each zero
      n_pc = (!m_en || m_pc == 0) ? m_presc : m_pc - 1;
      n_tc = m_tc;
      if (tick) begin
        if (m_tc > 1) n_tc = m_tc - 1;
        else if (m_tc == 1) n_tc = 0;
        else if (m_auto) n_tc = m_tload;
      end
      if (wr && off == 4'd2) n_tc = d;
      if (wr && off == 4'd4 && d[3]) m_done = 0;
      if (tick && m_tc == 1) m_done = 1;
      if (wr && off == 4'd6) m_bev = m_bev & ~d[3:0];
      m_bev = m_bev | (m_bh[1] & ~m_bh[2]);
      if (wr && off == 4'd0) m_led = d[9:0];
      if (wr && off == 4'd2) m_tload = d;
      if (wr && off == 4'd5) m_presc = d;
      if (wr && off == 4'd4) begin m_en = d[0]; m_auto = d[1]; m_ie = d[2]; end
      m_pc = n_pc;
      m_tc = n_tc;
      m_sh[1] = m_sh[0]; m_sh[0] = sw;
      m_bh[2] = m_bh[1]; m_bh[1] = m_bh[0]; m_bh[0] = btn;
    end
    e.led = m_led;
    e.irq = m_done & m_ie;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, a, 1'b0, 16'h0);
  endtask

  task automatic wrr(input logic [15:0] a, input logic [15:0] d);
    step(1'b1, a, 1'b1, d);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("hit_q", {15'b0, hit_q}, {15'b0, e.hit});
      chk("led", {6'b0, led}, {6'b0, e.led});
      chk("irq", {15'b0, irq}, {15'b0, e.irq});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a, d;
    logic [3:0]  off;
    @(negedge clk);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 16'h0);

    // LED write/readback and out-of-window read
    wrr(16'hFF00, 16'h03A5);
    rd(16'hFF00);
    rd(16'h0100);
    rd(16'hFF00);

    // switch synchronizer
    sw = 10'h155;
    for (int i = 0; i < 4; i++) rd(16'hFF01);

    // button edge flag, clear, and clear racing a new edge
    btn = 4'h4;
    for (int i = 0; i < 5; i++) rd(16'hFF06);
    wrr(16'hFF06, 16'h0004);
    rd(16'hFF06); rd(16'hFF06);
    btn = 4'h0;
    rd(16'hFF06); rd(16'hFF06); rd(16'hFF06);
    btn = 4'h4;
    for (int i = 0; i < 8; i++) begin
      if ((m_bh[1] & ~m_bh[2]) != 4'h0) begin
        wrr(16'hFF06, 16'h0004);
        break;
      end
      rd(16'hFF06);
    end
    rd(16'hFF06); rd(16'hFF06);

    // one-shot timer: PRESC=2, TLOAD=3, EN|IE
    wrr(16'hFF05, 16'h0002);
    wrr(16'hFF02, 16'h0003);
    wrr(16'hFF04, 16'h0005);
    for (int i = 0; i < 14; i++) rd(16'hFF03);
    rd(16'hFF04);

    // auto-reload, then DONE clear racing a new DONE
    wrr(16'hFF04, 16'h0008);
    wrr(16'hFF02, 16'h0003);
    wrr(16'hFF04, 16'h0007);
    for (int i = 0; i < 20; i++) rd(16'hFF03);
    wrr(16'hFF04, 16'h000F);
    rd(16'hFF04);
    for (int i = 0; i < 40; i++) begin
      if (m_en && m_pc == 0 && m_tc == 1) begin
        wrr(16'hFF04, 16'h000F);
        break;
      end
      rd(16'hFF03);
    end
    rd(16'hFF04); rd(16'hFF04);

    // TLOAD write coinciding with a tick
    for (int i = 0; i < 10; i++) begin
      if (m_en && m_pc == 0) begin
        wrr(16'hFF02, 16'h0010);
        break;
      end
      rd(16'hFF03);
    end
    rd(16'hFF03); rd(16'hFF03);

    // reset mid-count, overriding a same-cycle write
    step(1'b0, 16'hFF00, 1'b1, 16'hFFFF);
    for (int i = 0; i < 8; i++) rd(16'hFF00 | 16'(i));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sw = 10'($urandom);
      if ($urandom_range(3) == 0) btn = btn ^ 4'($urandom);
      if ($urandom_range(15) == 0) a = 16'($urandom);
      else a = 16'hFF00 | 16'($urandom_range(15));
      off = a[3:0];
      case (off)
        4'd2: d = 16'($urandom_range(5));
        4'd4: d = 16'($urandom_range(15));
        4'd5: d = 16'($urandom_range(3));
        default: d = 16'($urandom);
      endcase
      step(($urandom_range(299) != 0), a, ($urandom_range(2) == 0), d);
    end

    rd(16'h0000);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
